// File: rtl/image_scan_ctrl_if.sv
// Pixel stream bundle between the scan sequencer and its consumer.
// Carries one tagged pixel per valid/ready transfer.
interface image_scan_ctrl_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 8,
  parameter int PIX_W = 8
);
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic             pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_x,
    output pix_y,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_x,
    input  pix_y,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/image_scan_ctrl.sv
// Raster-scan sequencer: reads a frame from a latency-1 image memory
// and streams tagged pixels through a 2-entry skid buffer.
module image_scan_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int X_W    = 8,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  image_scan_ctrl_if.master pix,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;

  logic             r_inf;
  logic [X_W-1:0]   r_inf_x;
  logic [Y_W-1:0]   r_inf_y;
  logic             r_inf_last;

  logic [PIX_W-1:0] r_bd [2];
  logic [X_W-1:0]   r_bx [2];
  logic [Y_W-1:0]   r_by [2];
  logic             r_bl [2];
  logic             r_rp;
  logic             r_wp;
  logic [1:0]       r_cnt;

  logic [7:0]       r_fcnt;

  logic             w_pop;
  logic             w_push;
  logic             w_rd;
  logic             w_x_end;
  logic             w_last_px;
  logic [2:0]       w_occ;
  logic [1:0]       w_cnt_nxt;

  assign w_pop     = pix.pix_valid & pix.pix_ready;
  assign w_push    = r_inf;
  assign w_x_end   = (r_x == X_W'(IMG_W - 1));
  assign w_last_px = w_x_end & (r_y == Y_W'(IMG_H - 1));
  assign w_occ     = 3'(r_cnt) + 3'(r_inf);
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);

  // A read is only issued when its data is sure to find a free slot.
  assign w_rd = (r_state == S_RUN) & ~abort &
                ((w_occ < 3'd2) | ((w_occ == 3'd2) & w_pop));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_rd && w_last_px) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_cnt_nxt == 2'd0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DRAIN && w_state_nxt == S_DONE)
        r_fcnt <= r_fcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (abort || r_state == S_IDLE) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_rd) begin
      r_x <= w_x_end ? '0 : r_x + X_W'(1);
      if (w_x_end)
        r_y <= r_y + Y_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inf      <= 1'b0;
      r_inf_x    <= '0;
      r_inf_y    <= '0;
      r_inf_last <= 1'b0;
    end else begin
      r_inf <= w_rd;
      if (w_rd) begin
        r_inf_x    <= r_x;
        r_inf_y    <= r_y;
        r_inf_last <= w_last_px;
      end
    end
  end

  // Abort drops both the queued pixels and any read still returning.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rp  <= 1'b0;
      r_wp  <= 1'b0;
      r_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        r_bd[i] <= '0;
        r_bx[i] <= '0;
        r_by[i] <= '0;
        r_bl[i] <= 1'b0;
      end
    end else if (abort) begin
      r_rp  <= 1'b0;
      r_wp  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_bd[r_wp] <= mem_data;
        r_bx[r_wp] <= r_inf_x;
        r_by[r_wp] <= r_inf_y;
        r_bl[r_wp] <= r_inf_last;
        r_wp       <= ~r_wp;
      end
      if (w_pop)
        r_rp <= ~r_rp;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign mem_rd   = w_rd;
  assign mem_addr = ADDR_W'(r_y) * ADDR_W'(IMG_W) + ADDR_W'(r_x);

  assign pix.pix_valid = (r_cnt != 2'd0);
  assign pix.pix_data  = r_bd[r_rp];
  assign pix.pix_x     = r_bx[r_rp];
  assign pix.pix_y     = r_by[r_rp];
  assign pix.pix_last  = r_bl[r_rp];

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Bench for image_scan_ctrl on a 4x3 frame backed by ROM[a] = a*7.
// Table-driven nominal frame plus randomized backpressure scenarios.
module tb_image_scan_ctrl;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int X_W    = 2;
  localparam int Y_W    = 2;
  localparam int ADDR_W = 4;
  localparam int PIX_W  = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data;
  logic              busy;
  logic              done;
  logic [7:0]        frame_cnt;

  image_scan_ctrl_if #(.X_W(X_W), .Y_W(Y_W), .PIX_W(PIX_W)) pix ();

  image_scan_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .pix      (pix),
    .busy     (busy),
    .done     (done),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rom(int a);
    return (a * 7) % 256;
  endfunction

  always @(posedge clk)
    if (mem_rd) mem_data <= PIX_W'(rom(int'(mem_addr)));

  int checks;
  int errors;
  int exp_idx;
  int reads;
  int n_done;
  int fc_model;
  bit seen_done;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_mem_rd"},    int'(mem_rd), 0);
    chk({tag, "_mem_addr"},  int'(mem_addr), 0);
    chk({tag, "_pix_valid"}, int'(pix.pix_valid), 0);
    chk({tag, "_pix_data"},  int'(pix.pix_data), 0);
    chk({tag, "_pix_x"},     int'(pix.pix_x), 0);
    chk({tag, "_pix_y"},     int'(pix.pix_y), 0);
    chk({tag, "_pix_last"},  int'(pix.pix_last), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  // One cycle of observation against the frame-order reference.
  task automatic mon();
    bit pop;
    #1;
    pop = pix.pix_valid && pix.pix_ready;
    if (pix.pix_valid) begin
      if (exp_idx < NPIX) begin
        chk("pix_x",    int'(pix.pix_x),    exp_idx % IMG_W);
        chk("pix_y",    int'(pix.pix_y),    exp_idx / IMG_W);
        chk("pix_data", int'(pix.pix_data), rom(exp_idx));
        chk("pix_last", int'(pix.pix_last), int'(exp_idx == NPIX - 1));
      end else begin
        chk("extra_pixel", exp_idx, NPIX - 1);
      end
    end
    if (mem_rd) begin
      chk("mem_addr", int'(mem_addr), reads);
      chk("fetch_window", int'((reads - exp_idx - int'(pop)) < 2), 1);
      chk("rd_busy", int'(busy), 1);
      reads++;
    end
    if (pop) exp_idx++;
    if (done) begin
      seen_done = 1'b1;
      n_done++;
      fc_model = (fc_model + 1) % 256;
      chk("done_pixels", exp_idx, NPIX);
      chk("frame_cnt", int'(frame_cnt), fc_model);
    end
    @(negedge clk);
  endtask

  // mode 0: ready=1; 1: stall 3..12 then random; 2: ready=1 with
  // a stray start mid-frame; 3: random ready throughout.
  task automatic run_frame(int mode);
    exp_idx   = 0;
    reads     = 0;
    seen_done = 1'b0;
    start     = 1'b1;
    pix.pix_ready = 1'b1;
    mon();
    start = 1'b0;
    for (int k = 0; k < 300 && !seen_done; k++) begin
      case (mode)
        1: pix.pix_ready = (k < 3) ? 1'b1 :
                           (k <= 12) ? 1'b0 : 1'($urandom % 2);
        3: pix.pix_ready = 1'($urandom % 2);
        default: pix.pix_ready = 1'b1;
      endcase
      start = (mode == 2 && k == 5);
      mon();
    end
    start = 1'b0;
    if (!seen_done) chk("frame_timeout", 0, 1);
    #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    @(negedge clk);
  endtask

  typedef struct {
    bit ready;
    int rd;
    int addr;
    int valid;
    int x;
    int y;
    int data;
    int last;
    int dn;
    int bsy;
    int fcnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int fc0;
    int pix_total;
    int n_done0;

    for (int k = 0; k < 16; k++) begin
      tbl[k].ready = 1'b1;
      tbl[k].rd    = int'(k <= NPIX - 1);
      tbl[k].addr  = k;
      tbl[k].valid = int'(k >= 2 && k <= NPIX + 1);
      tbl[k].x     = (k - 2) % IMG_W;
      tbl[k].y     = (k - 2) / IMG_W;
      tbl[k].data  = rom(k - 2);
      tbl[k].last  = int'(k == NPIX + 1);
      tbl[k].dn    = int'(k == NPIX + 2);
      tbl[k].bsy   = int'(k <= NPIX + 2);
      tbl[k].fcnt  = (k >= NPIX + 2) ? 1 : 0;
    end

    checks   = 0;
    errors   = 0;
    n_done   = 0;
    fc_model = 0;
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    pix.pix_ready = 1'b0;
    #2;
    check_zero("por");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Async reset in the middle of a frame.
    exp_idx = 0;
    reads   = 0;
    start   = 1'b1;
    pix.pix_ready = 1'b1;
    mon();
    start = 1'b0;
    repeat (5) mon();
    rst = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    fc_model = 0;
    @(negedge clk);

    // Nominal frame with ready held high, cycle-exact.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pix.pix_ready = tbl[k].ready;
      #1;
      chk("t_mem_rd", int'(mem_rd), tbl[k].rd);
      if (tbl[k].rd != 0)
        chk("t_mem_addr", int'(mem_addr), tbl[k].addr);
      chk("t_pix_valid", int'(pix.pix_valid), tbl[k].valid);
      if (tbl[k].valid != 0) begin
        chk("t_pix_x",    int'(pix.pix_x),    tbl[k].x);
        chk("t_pix_y",    int'(pix.pix_y),    tbl[k].y);
        chk("t_pix_data", int'(pix.pix_data), tbl[k].data);
        chk("t_pix_last", int'(pix.pix_last), tbl[k].last);
      end
      chk("t_done",      int'(done),      tbl[k].dn);
      chk("t_busy",      int'(busy),      tbl[k].bsy);
      chk("t_frame_cnt", int'(frame_cnt), tbl[k].fcnt);
      @(negedge clk);
    end
    fc_model = 1;

    // Backpressure: long stall then random ready.
    run_frame(1);

    // Abort after the fifth transfer.
    exp_idx = 0;
    reads   = 0;
    start   = 1'b1;
    pix.pix_ready = 1'b1;
    mon();
    start = 1'b0;
    for (int k = 0; k < 50 && exp_idx < 5; k++) mon();
    chk("abort_reach5", exp_idx, 5);
    abort = 1'b1;
    pix.pix_ready = 1'b0;
    mon();
    abort = 1'b0;
    pix.pix_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("abort_valid", int'(pix.pix_valid), 0);
      chk("abort_mem_rd", int'(mem_rd), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_fcnt", int'(frame_cnt), fc_model);
      @(negedge clk);
    end
    run_frame(0);

    // Stray start while busy is ignored.
    run_frame(2);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    #1;
    chk("sa_mem_rd_same", int'(mem_rd), 0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sa_busy", int'(busy), 0);
      chk("sa_mem_rd", int'(mem_rd), 0);
      chk("sa_valid", int'(pix.pix_valid), 0);
      @(negedge clk);
    end

    // Three back-to-back frames under random backpressure.
    fc0       = fc_model;
    n_done0   = n_done;
    pix_total = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame(3);
      pix_total += exp_idx;
    end
    #1;
    chk("b2b_frame_cnt", int'(frame_cnt), (fc0 + 3) % 256);
    chk("b2b_pixels", pix_total, 3 * NPIX);
    chk("b2b_dones", n_done - n_done0, 3);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
